scope_3ph_axi_regs: RTL

SCOPE_3PH_AXI_REGS -- requirements
Module: scope_3ph_axi_regs

---
 rtl/scope_3ph_axi_pkg.sv | 36 +++
 rtl/scope_3ph_axi_wr_fsm.sv | 111 +++++++++++
 rtl/scope_3ph_axi_regs.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/scope_3ph_axi_pkg.sv
// Shared constants and types for the 3-phase scope AXI4-Lite register slice.
// Build option: define SCOPE_AXI_SLVERR_EN to answer unmapped word slots with SLVERR.
package scope_3ph_axi_pkg;

    localparam int unsigned IDX_W         = 4;
    localparam int unsigned IDX_LSB       = 2;
    localparam int unsigned NUM_CTRL      = 4;
    localparam int unsigned NUM_STAT      = 4;

    localparam logic [IDX_W-1:0] IDX_CTRL_LAST = 4'd3;
    localparam logic [IDX_W-1:0] IDX_STAT_LAST = 4'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef SCOPE_AXI_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_UNMAPPED = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAVE_ADDR = 2'd1,
        HAVE_DATA = 2'd2,
        RESP      = 2'd3
    } wr_state_e;

    // Slots 8-15 are unmapped; everything below answers OKAY.
    function automatic logic [1:0] idx_resp(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1] ? RESP_UNMAPPED : RESP_OKAY;
    endfunction

endpackage

// File: rtl/scope_3ph_axi_wr_fsm.sv
// AW/W capture and B-channel response for the scope register slice.
// Address and data may arrive in either order or together; the write fires
// in the cycle the second of the two is accepted.
module scope_3ph_axi_wr_fsm
    import scope_3ph_axi_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      awidx_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  wr_en_c_o,
    output logic [IDX_W-1:0]      wr_idx_c_o,
    output logic [DATA_W-1:0]     wr_data_c_o,
    output logic [DATA_W/8-1:0]   wr_strb_c_o
);

    wr_state_e             state_q, state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W/8-1:0]   strb_q, strb_d;
    logic                  aw_hs, w_hs, wr_en_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic [DATA_W-1:0]     wr_data_c;
    logic [DATA_W/8-1:0]   wr_strb_c;

    // State, latches and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    // Next state, latch capture and write strobe; a held beat is merged with the arriving one.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        strb_d    = strb_q;
        bresp_d   = bresp_q;
        aw_hs     = awvalid_i & awready_q;
        w_hs      = wvalid_i & wready_q;
        wr_idx_c  = (state_q == HAVE_ADDR) ? idx_q  : awidx_i;
        wr_data_c = (state_q == HAVE_DATA) ? data_q : wdata_i;
        wr_strb_c = (state_q == HAVE_DATA) ? strb_q : wstrb_i;
        wr_en_c   = ((state_q == HAVE_ADDR) | aw_hs) & ((state_q == HAVE_DATA) | w_hs);

        if (aw_hs) idx_d = awidx_i;
        if (w_hs) begin
            data_d = wdata_i;
            strb_d = wstrb_i;
        end

        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) state_d = RESP;
                else if (aw_hs)    state_d = HAVE_ADDR;
                else if (w_hs)     state_d = HAVE_DATA;
            end
            HAVE_ADDR: if (w_hs)     state_d = RESP;
            HAVE_DATA: if (aw_hs)    state_d = RESP;
            RESP:      if (bready_i) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase

        if (wr_en_c) bresp_d = idx_resp(wr_idx_c);

        awready_d = (state_d == IDLE) || (state_d == HAVE_DATA);
        wready_d  = (state_d == IDLE) || (state_d == HAVE_ADDR);
        bvalid_d  = (state_d == RESP);
    end

    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign bvalid_o    = bvalid_q;
    assign bresp_o     = bresp_q;
    assign wr_en_c_o   = wr_en_c;
    assign wr_idx_c_o  = wr_idx_c;
    assign wr_data_c_o = wr_data_c;
    assign wr_strb_c_o = wr_strb_c;

endmodule

// File: rtl/scope_3ph_axi_regs.sv
// AXI4-Lite register slice for the 3-phase scope: four RW control words,
// four RO status words sampled on read, and a per-register write strobe.
// Build option: SCOPE_AXI_SLVERR_EN (see scope_3ph_axi_pkg).
module scope_3ph_axi_regs
    import scope_3ph_axi_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg3,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     stat_in4,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     stat_in5,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     stat_in6,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     stat_in7,
    output logic [NUM_CTRL-1:0]               wr_pulse
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0]       ctrl_q [NUM_CTRL];
    logic [DW-1:0]       ctrl_d [NUM_CTRL];
    logic [DW-1:0]       stat_c [NUM_STAT];
    logic [NUM_CTRL-1:0] wr_pulse_q, wr_pulse_d;
    logic                wr_en_c;
    logic [IDX_W-1:0]    wr_idx_c, rd_idx_c;
    logic [DW-1:0]       wr_data_c, rd_word_c;
    logic [SW-1:0]       wr_strb_c;
    logic [1:0]          rd_resp_c;
    logic                ar_hs;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[IDX_LSB-1:0], S_AXI_ARADDR[IDX_LSB-1:0]};

    scope_3ph_axi_wr_fsm #(
        .DATA_W (DW)
    ) u_wr_fsm (
        .clk         (S_AXI_ACLK),
        .rst_n       (S_AXI_ARESETN),
        .awidx_i     (S_AXI_AWADDR[IDX_LSB +: IDX_W]),
        .awvalid_i   (S_AXI_AWVALID),
        .awready_o   (S_AXI_AWREADY),
        .wdata_i     (S_AXI_WDATA),
        .wstrb_i     (S_AXI_WSTRB),
        .wvalid_i    (S_AXI_WVALID),
        .wready_o    (S_AXI_WREADY),
        .bresp_o     (S_AXI_BRESP),
        .bvalid_o    (S_AXI_BVALID),
        .bready_i    (S_AXI_BREADY),
        .wr_en_c_o   (wr_en_c),
        .wr_idx_c_o  (wr_idx_c),
        .wr_data_c_o (wr_data_c),
        .wr_strb_c_o (wr_strb_c)
    );

    // Byte-masked update of the control words and the matching one-cycle strobe.
    always_comb begin
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        if (wr_en_c && (wr_idx_c <= IDX_CTRL_LAST)) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_strb_c[b]) ctrl_d[wr_idx_c[1:0]][8*b +: 8] = wr_data_c[8*b +: 8];
            end
            wr_pulse_d[wr_idx_c[1:0]] = 1'b1;
        end
    end

    // Read decode; status words are sampled live at the AR handshake.
    always_comb begin
        stat_c    = '{stat_in4, stat_in5, stat_in6, stat_in7};
        rd_idx_c  = S_AXI_ARADDR[IDX_LSB +: IDX_W];
        rd_resp_c = idx_resp(rd_idx_c);
        rd_word_c = '0;
        if (rd_idx_c <= IDX_CTRL_LAST)      rd_word_c = ctrl_q[rd_idx_c[1:0]];
        else if (rd_idx_c <= IDX_STAT_LAST) rd_word_c = stat_c[rd_idx_c[1:0]];
    end

    // R channel: one outstanding read, held until RREADY.
    always_comb begin
        ar_hs    = S_AXI_ARVALID & arready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word_c;
            rresp_d  = rd_resp_c;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    // Register file and read-channel registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign ctrl_reg0     = ctrl_q[0];
    assign ctrl_reg1     = ctrl_q[1];
    assign ctrl_reg2     = ctrl_q[2];
    assign ctrl_reg3     = ctrl_q[3];
    assign wr_pulse      = wr_pulse_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule
